idli_sqi_ctrl: RTL and testbench
================================

IDLI_SQI_CTRL -- requirements
Module: idli_sqi_ctrl

Interface
REQ-001 SHALL have one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-002 Ports SHALL be exactly:
- i_clk  in  1  core clock
- i_rst  in  1  sync active-high reset
- i_redirect  in  1  start a new transaction at i_addr
- i_addr  in  16  word address
- i_wr  in  1  transaction type, sampled with i_redirect (1 write, 0 read)
- i_stop  in  1  end the current transaction
- i_hold  in  1  consumer stall in data phase
- i_slice  in  4  write slice
- o_ready  out  1  i_slice is consumed this cycle
- o_slice  out  4  read slice
- o_valid  out  1  o_slice valid this cycle
- o_ctr  out  2  slice index within the 16b word of the slice moved last
- o_busy  out  1  transaction active
- o_cs_n  out  1  SQI chip select, active-low
- o_sck_en  out  1  SQI clock enable (board gates i_clk with it)
- o_sio  out  4  SQI data out
- o_sio_oe  out  1  SQI output enable
- i_sio  in  4  SQI data in

Function
REQ-003 All outputs except o_ready SHALL be registered.
REQ-004 States SHALL be IDLE, GAP, CMD, ADDR, DUMMY and DATA.
- CMD lasts 2 cycles.
- ADDR lasts 6 cycles.
- DUMMY lasts 2 cycles and is used for reads only.
- GAP lasts 1 cycle.
REQ-005 Cycle 0 is the cycle where i_redirect is high while in IDLE; CMD SHALL occupy cycles 1-2, ADDR cycles 3-8, DUMMY cycles 9-10 (read), and DATA starts in cycle 11 (read) or cycle 9 (write).
REQ-006 CMD nibbles SHALL be high nibble first: 0x03 for read, 0x02 for write.
REQ-007 The ADDR nibbles SHALL be the 24-bit byte address {7'b0, i_addr, 1'b0}, MSB nibble first; i_addr and i_wr are latched in cycle 0.
REQ-008 In non-IDLE, non-GAP states, o_cs_n SHALL be 0 and o_sck_en SHALL be 1, except during hold (REQ-012).
REQ-009 o_sio_oe SHALL be 1 in CMD, in ADDR and in write DATA, and 0 otherwise.
REQ-010 For a read in DATA, i_sio SHALL be sampled at the end of each cycle with o_sck_en=1 and presented on o_slice with o_valid=1 in the next cycle; the first o_valid is in cycle 12.
REQ-011 For a write, o_ready SHALL equal !i_hold when in the last ADDR cycle or in write DATA, and 0 otherwise.
- When o_ready=1, i_slice is registered onto o_sio for the next cycle.
- The first write nibble is driven in cycle 9.
REQ-012 i_hold high in cycle t during DATA (or in the last ADDR cycle for writes) SHALL have these effects:
- cycle t+1 has o_sck_en=0 and o_sio held;
- no slice is sampled or consumed;
- o_cs_n stays 0.
REQ-013 i_hold SHALL be ignored in all other states.
REQ-014 o_ctr SHALL be set to 0 on redirect and increment by 1 for every slice transferred (o_valid, or o_ready handshake), wrapping from 3 to 0.
REQ-015 Slices SHALL pass in wire order with no reordering; the memory image is stored so that wire order equals slice 0..3 of each word.
REQ-016 DATA SHALL continue indefinitely, with the SRAM auto-incrementing, until i_stop or i_redirect.
REQ-017 i_stop in any non-IDLE state SHALL cause IDLE next cycle with o_cs_n=1, o_sck_en=0, o_sio_oe=0 and o_valid=0.
REQ-018 i_redirect in a non-IDLE state SHALL cause GAP next cycle (o_cs_n=1), then CMD; all REQ-005 cycle numbers shift by +1.
REQ-019 i_redirect SHALL take precedence over i_stop when both are high.
REQ-020 i_stop in IDLE SHALL be ignored.
REQ-021 o_busy SHALL be 1 in every state other than IDLE.

Reset
REQ-022 While i_rst=1 in cycle t, the block SHALL be in IDLE in cycle t+1 with the following outputs:
- o_cs_n=1;
- o_sck_en=0, o_sio=0, o_sio_oe=0;
- o_valid=0, o_slice=0;
- o_ctr=0, o_busy=0;
- o_ready=0.
REQ-023 Reset SHALL override redirect/stop and abort any transaction mid-phase.

Verification
REQ-024 Read with i_addr=0x1234, no hold -> o_sio sequence 0,3,0,0,2,4,6,8; o_sio_oe=0 in cycles 9-10; i_sio nibbles A,B,C,D in cycles 11-14 -> o_slice A,B,C,D with o_valid in cycles 12-15 and o_ctr 0,1,2,3.
REQ-025 Write to i_addr=0x0001 with slices 5,6,7,8 -> o_sio 0,2,0,0,0,0,0,2 then 5,6,7,8 in cycles 9-12; o_ready high in cycles 8-11.
REQ-026 Read with i_hold high in cycle 13 -> o_sck_en=0 in cycle 14, no o_valid in cycle 15; stream resumes and o_ctr skips no value.
REQ-027 Redirect in cycle 12 of a read -> o_cs_n=1 in cycle 13; CMD nibble 0 in cycle 14; o_ctr=0.
REQ-028 i_rst in cycle 5 of a write -> all REQ-022 reset values in cycle 6; stop and redirect asserted together in IDLE -> redirect is honoured.
REQ-029 Read of 9 slices -> o_ctr wraps 3 to 0; then i_stop -> o_cs_n=1 and o_busy=0 the next cycle.

Source files
------------

// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: quad-SPI (SQI) SRAM controller.
// Runs a streaming read or write: 2 command nibbles, 6 address nibbles,
// 2 dummy cycles for reads, then an open-ended data phase of 4-bit slices.
// Every output except o_ready comes straight from a flop.
module idli_sqi_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [15:0] i_addr,
  input  logic        i_wr,
  input  logic        i_stop,
  input  logic        i_hold,
  input  logic [3:0]  i_slice,
  output logic        o_ready,
  output logic [3:0]  o_slice,
  output logic        o_valid,
  output logic [1:0]  o_ctr,
  output logic        o_busy,
  output logic        o_cs_n,
  output logic        o_sck_en,
  output logic [3:0]  o_sio,
  output logic        o_sio_oe,
  input  logic [3:0]  i_sio
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA
  } state_t;

  localparam logic [7:0] CMD_RD = 8'h03;
  localparam logic [7:0] CMD_WR = 8'h02;

  state_t      r_state;
  logic [2:0]  r_cnt;      // cycle index within CMD/ADDR/DUMMY
  logic [15:0] r_addr;
  logic        r_wr;
  logic        r_cs_n;
  logic        r_sck_en;
  logic [3:0]  r_sio;
  logic        r_sio_oe;
  logic        r_valid;
  logic [3:0]  r_slice;
  logic [1:0]  r_ctr;
  logic        r_busy;

  logic [23:0] w_baddr;
  logic [2:0]  w_nib_sel;
  logic [3:0]  w_addr_nib;
  logic        w_last_addr;
  logic        w_xfer;

  // The SRAM is byte addressed; a word address becomes an even byte address.
  assign w_baddr     = {7'b0, r_addr, 1'b0};
  assign w_last_addr = (r_state == S_ADDR) && (r_cnt == 3'd5);

  // Write slices are taken from the last address cycle on, so the first one
  // is already on the wire in the first data cycle.
  assign o_ready = r_wr && !i_hold && (w_last_addr || (r_state == S_DATA));
  assign w_xfer  = r_valid || o_ready;

  assign o_slice  = r_slice;
  assign o_valid  = r_valid;
  assign o_ctr    = r_ctr;
  assign o_busy   = r_busy;
  assign o_cs_n   = r_cs_n;
  assign o_sck_en = r_sck_en;
  assign o_sio    = r_sio;
  assign o_sio_oe = r_sio_oe;

  // Address nibble to drive next cycle: nibble 0 after the last CMD cycle,
  // otherwise the one after the current ADDR cycle (MSB nibble first).
  always_comb begin
    w_nib_sel  = (r_state == S_CMD) ? 3'd0 : r_cnt + 3'd1;
    w_addr_nib = 4'h0;
    case (w_nib_sel)
      3'd0:    w_addr_nib = w_baddr[23:20];
      3'd1:    w_addr_nib = w_baddr[19:16];
      3'd2:    w_addr_nib = w_baddr[15:12];
      3'd3:    w_addr_nib = w_baddr[11:8];
      3'd4:    w_addr_nib = w_baddr[7:4];
      3'd5:    w_addr_nib = w_baddr[3:0];
      default: w_addr_nib = 4'h0;
    endcase
  end

  // Transaction FSM; all bus and stream outputs are set for the next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_addr   <= 16'h0;
      r_wr     <= 1'b0;
      r_cs_n   <= 1'b1;
      r_sck_en <= 1'b0;
      r_sio    <= 4'h0;
      r_sio_oe <= 1'b0;
      r_valid  <= 1'b0;
      r_slice  <= 4'h0;
      r_busy   <= 1'b0;
    end else if (i_redirect) begin
      // Redirect beats stop. From a live transaction, deselect for one
      // cycle first so the SRAM sees a fresh command.
      r_addr  <= i_addr;
      r_wr    <= i_wr;
      r_cnt   <= 3'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
      if (r_state == S_IDLE) begin
        r_state  <= S_CMD;
        r_cs_n   <= 1'b0;
        r_sck_en <= 1'b1;
        r_sio    <= i_wr ? CMD_WR[7:4] : CMD_RD[7:4];
        r_sio_oe <= 1'b1;
      end else begin
        r_state  <= S_GAP;
        r_cs_n   <= 1'b1;
        r_sck_en <= 1'b0;
        r_sio_oe <= 1'b0;
      end
    end else if (i_stop && (r_state != S_IDLE)) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_cs_n   <= 1'b1;
      r_sck_en <= 1'b0;
      r_sio_oe <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_GAP: begin
          r_state  <= S_CMD;
          r_cnt    <= 3'd0;
          r_cs_n   <= 1'b0;
          r_sck_en <= 1'b1;
          r_sio    <= r_wr ? CMD_WR[7:4] : CMD_RD[7:4];
          r_sio_oe <= 1'b1;
        end
        S_CMD: begin
          if (r_cnt == 3'd0) begin
            r_cnt <= 3'd1;
            r_sio <= r_wr ? CMD_WR[3:0] : CMD_RD[3:0];
          end else begin
            r_state <= S_ADDR;
            r_cnt   <= 3'd0;
            r_sio   <= w_addr_nib;
          end
        end
        S_ADDR: begin
          if (r_cnt != 3'd5) begin
            r_cnt <= r_cnt + 3'd1;
            r_sio <= w_addr_nib;
          end else if (r_wr) begin
            // Hold here stalls the first write slice.
            r_state  <= S_DATA;
            r_cnt    <= 3'd0;
            r_sck_en <= !i_hold;
            if (!i_hold) r_sio <= i_slice;
          end else begin
            r_state  <= S_DUMMY;
            r_cnt    <= 3'd0;
            r_sio    <= 4'h0;
            r_sio_oe <= 1'b0;
          end
        end
        S_DUMMY: begin
          if (r_cnt == 3'd0) begin
            r_cnt <= 3'd1;
          end else begin
            r_state <= S_DATA;
            r_cnt   <= 3'd0;
          end
        end
        S_DATA: begin
          // A held cycle gates the SRAM clock, so nothing moves on the wire.
          r_sck_en <= !i_hold;
          if (r_wr) begin
            if (!i_hold) r_sio <= i_slice;
          end else if (r_sck_en) begin
            r_slice <= i_sio;
            r_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Slice index: cleared by redirect, advances once per slice moved.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_redirect) begin
      r_ctr <= 2'd0;
    end else if (w_xfer) begin
      r_ctr <= r_ctr + 2'd1;
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Bench for idli_sqi_ctrl: a behavioural SQI SRAM on the bus plus a
// scoreboard of expected headers, write nibbles and read slices.
module tb_idli_sqi_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_redirect = 1'b0;
  logic [15:0] i_addr = 16'h0;
  logic        i_wr = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_hold = 1'b0;
  logic [3:0]  i_slice = 4'h0;
  logic [3:0]  i_sio = 4'h0;
  logic        o_ready, o_valid, o_busy, o_cs_n, o_sck_en, o_sio_oe;
  logic [3:0]  o_slice, o_sio;
  logic [1:0]  o_ctr;

  idli_sqi_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_addr(i_addr),
    .i_wr(i_wr), .i_stop(i_stop), .i_hold(i_hold), .i_slice(i_slice),
    .o_ready(o_ready), .o_slice(o_slice), .o_valid(o_valid), .o_ctr(o_ctr),
    .o_busy(o_busy), .o_cs_n(o_cs_n), .o_sck_en(o_sck_en), .o_sio(o_sio),
    .o_sio_oe(o_sio_oe), .i_sio(i_sio)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic void bad(string nm);
    n_tot++;
    $display("FAIL %s: event occurred, expected none (cycle %0d)", nm, cyc);
  endfunction

  // Reference memory (nibble addressed, wire order) and the SRAM's own copy.
  logic [3:0] ref_mem [int];
  logic [3:0] sram    [int];

  function automatic logic [3:0] seed_nib(int na);
    return 4'((na * 13 + (na >> 5)) & 15);
  endfunction
  function automatic logic [3:0] ref_rd(int na);
    return ref_mem.exists(na) ? ref_mem[na] : seed_nib(na);
  endfunction
  function automatic logic [3:0] sram_rd(int na);
    return sram.exists(na) ? sram[na] : seed_nib(na);
  endfunction

  logic [31:0] hq[$];   // {cmd, byte address}
  logic [3:0]  wq[$];   // write nibbles in wire order
  logic [5:0]  rq[$];   // {ctr, slice}

  // SQI SRAM: counts clocked nibbles since select, decodes the header,
  // stores write data and drives read data auto-incrementing.
  int          sn = 0;
  logic [31:0] hdr = 32'h0;
  int          na = 0;
  bit          swr = 1'b0;
  always @(negedge i_clk) begin
    if (o_cs_n !== 1'b0) begin
      sn = 0;
    end else if (o_sck_en) begin
      if (sn < 8) begin
        chk("hdr_oe", o_sio_oe, 1);
        hdr = {hdr[27:0], o_sio};
        if (sn == 7) begin
          if (hq.size() == 0) bad("hdr_unexpected");
          else chk("hdr", hdr, hq.pop_front());
          swr = (hdr[31:24] == 8'h02);
          na  = int'(hdr[23:0]) * 2;
        end
      end else if (swr) begin
        chk("wr_oe", o_sio_oe, 1);
        if (wq.size() == 0) bad("wr_unexpected");
        else chk("wr_nib", o_sio, wq.pop_front());
        sram[na] = o_sio;
        na++;
      end else begin
        chk("rd_oe", o_sio_oe, 0);
        if (sn >= 10) begin
          i_sio = sram_rd(na);
          na++;
        end
      end
      sn++;
    end
  end

  // Read-stream monitor.
  logic [5:0] me;
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      if (rq.size() == 0) bad("rd_unexpected");
      else begin
        me = rq.pop_front();
        chk("rd_slice", o_slice, me[3:0]);
        chk("rd_ctr", o_ctr, me[5:4]);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [3:0] hnib(logic [31:0] hv, int k);
    return 4'((hv >> (4 * (8 - k))) & 32'hF);
  endfunction

  task automatic check_reset(string nm);
    chk({nm, "_cs_n"}, o_cs_n, 1);   chk({nm, "_sck"}, o_sck_en, 0);
    chk({nm, "_sio"}, o_sio, 0);     chk({nm, "_oe"}, o_sio_oe, 0);
    chk({nm, "_valid"}, o_valid, 0); chk({nm, "_slice"}, o_slice, 0);
    chk({nm, "_ctr"}, o_ctr, 0);     chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_ready"}, o_ready, 0);
  endtask

  // Issue a read in the current cycle; returns in the cycle of the n-th slice
  // (chain=1) or one cycle after a stop in that cycle.
  task automatic do_read(input logic [15:0] a, input int n, input int hold_at,
                         input bit chain, input bit from_busy, input bit dir,
                         input bit with_stop);
    int t0, got, lat, off;
    bit done;
    logic [31:0] hv;
    lat = from_busy ? 1 : 0;
    hv  = {8'h03, 7'b0, a, 1'b0};
    hq.push_back(hv);
    for (int i = 0; i < n; i++) rq.push_back({2'(i % 4), ref_rd(int'(a) * 4 + i)});
    i_redirect = 1; i_addr = a; i_wr = 0; i_stop = with_stop; i_hold = 0;
    t0 = cyc; got = 0; done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      step();
      i_redirect = 0; i_stop = 0;
      off = cyc - t0;
      i_hold = (hold_at >= 0) && (off == hold_at + lat);
      if (dir) begin
        if (lat == 1 && off == 1) chk("gap_cs_n", o_cs_n, 1);
        if (lat == 1 && off == 2) chk("redir_ctr", o_ctr, 0);
        if (off - lat >= 1 && off - lat <= 8) begin
          chk("rd_hdr_sio", o_sio, hnib(hv, off - lat));
          chk("rd_hdr_cs", o_cs_n, 0);
        end
        if (off - lat == 9 || off - lat == 10) chk("dummy_oe", o_sio_oe, 0);
        if (off - lat == 11) chk("first_valid_early", o_valid, 0);
        if (off - lat == 12) chk("first_valid", o_valid, 1);
      end
      if (hold_at >= 0 && off == hold_at + lat + 1) chk("hold_sck", o_sck_en, 0);
      if (hold_at >= 0 && off == hold_at + lat + 2) chk("hold_valid", o_valid, 0);
      if (o_valid) got++;
      if (got == n) done = 1;
    end
    if (!done) bad("rd_timeout");
    if (!chain) begin
      i_stop = 1; i_hold = 0;
      step();
      i_stop = 0;
      chk("stop_cs_n", o_cs_n, 1); chk("stop_busy", o_busy, 0);
      chk("stop_sck", o_sck_en, 0); chk("stop_valid", o_valid, 0);
    end
  endtask

  // Issue a write of n slices in the current cycle, then stop.
  task automatic do_write(input logic [15:0] a, input int n, input int hold_at,
                          input bit dir, input logic [31:0] pat, input bit use_pat);
    logic [3:0] s[$];
    int t0, idx, off;
    logic [31:0] hv;
    hv = {8'h02, 7'b0, a, 1'b0};
    hq.push_back(hv);
    for (int i = 0; i < n; i++) begin
      s.push_back(use_pat ? 4'((pat >> (4 * (7 - i))) & 32'hF) : 4'($urandom_range(0, 15)));
      wq.push_back(s[i]);
      ref_mem[int'(a) * 4 + i] = s[i];
    end
    i_redirect = 1; i_addr = a; i_wr = 1; i_stop = 0; i_hold = 0;
    t0 = cyc; idx = 0;
    for (int k = 0; k < 300 && idx < n; k++) begin
      step();
      i_redirect = 0;
      off = cyc - t0;
      i_hold  = (off == hold_at);
      i_slice = s[idx];
      #1;
      if (dir) begin
        if (off >= 1 && off <= 8) chk("wr_hdr_sio", o_sio, hnib(hv, off));
        if (off >= 7 && off <= 11) chk("wr_ready", o_ready, int'(off >= 8));
        if (off >= 9 && off <= 11) chk("wr_data_sio", o_sio, s[off - 9]);
      end
      if (o_ready) idx++;
    end
    if (idx < n) bad("wr_timeout");
    step();
    i_stop = 1; i_hold = 0;
    step();
    i_stop = 0;
    chk("wr_stop_busy", o_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    int n, h;
    // Contents at word 0x1234: A,B,C,D in wire order.
    for (int i = 0; i < 4; i++) begin
      ref_mem[16'h1234 * 4 + i] = 4'(10 + i);
      sram[16'h1234 * 4 + i]    = 4'(10 + i);
    end
    step();
    step();
    check_reset("por");
    i_rst = 0;
    step();

    do_read(16'h1234, 4, -1, 0, 0, 1, 0);
    do_write(16'h0001, 4, -1, 1, 32'h5678_0000, 1);
    do_read(16'h0001, 4, -1, 0, 0, 0, 0);
    do_read(16'h1234, 6, 13, 0, 0, 1, 0);
    do_read(16'h1234, 1, -1, 1, 0, 0, 0);
    do_read(16'h0001, 4, -1, 0, 1, 1, 0);

    // Reset in the middle of a write header.
    i_redirect = 1; i_addr = 16'h0abc; i_wr = 1;
    repeat (5) begin
      step();
      i_redirect = 0;
    end
    i_rst = 1;
    step();
    i_rst = 0;
    check_reset("rst_mid");

    do_read(16'h1234, 4, -1, 0, 0, 1, 1);
    do_read(16'h0200, 9, -1, 0, 0, 0, 0);

    for (int it = 0; it < 10; it++) begin
      a = 16'h0200 + 16'($urandom_range(0, 15) * 4);
      n = int'($urandom_range(1, 8));
      h = ($urandom_range(0, 1) == 1) ? 8 + int'($urandom_range(0, n - 1)) : -1;
      do_write(a, n, h, 0, 32'h0, 0);
      a = 16'h0200 + 16'($urandom_range(0, 15) * 4);
      n = int'($urandom_range(1, 9));
      h = ($urandom_range(0, 1) == 1) ? 11 + int'($urandom_range(0, n - 1)) : -1;
      do_read(a, n, h, 0, 0, 0, 0);
    end

    repeat (4) step();
    chk("hq_empty", hq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
